apb_mem_bridge: RTL and testbench
=================================

Name: apb_mem_bridge

Overview:
- APB slave that turns APB transfers into single-word accesses on the team's simple memory interface (en / wr_rd / address / write_data / read_data / data_ready).
- Sits between the APB interconnect and a MEM instance. It is the initiator on the memory side and the responder on the APB side.
- Adds address decode, alignment checking, error response and an optional access timeout.

Parameters:
- ADDR_WIDTH, 32, APB byte-address width and memory address port width.
- DATA_WIDTH, 32, data width. Byte-lane shift ADDR_LSB = $clog2(DATA_WIDTH/8), derived locally.
- MEM_DEPTH, 64, number of memory words. Valid word index range is 0..MEM_DEPTH-1.
- TIMEOUT_CYCLES, 16, maximum cycles spent in MEM before an error response. Used only with the optional feature.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  APB byte address.
- pwdata  in  DATA_WIDTH  APB write data.
- prdata  out  DATA_WIDTH  APB read data, registered.
- pready  out  1  APB ready, registered, one-cycle pulse.
- pslverr  out  1  APB error, valid only with pready.
- mem_en  out  1  memory enable, registered.
- mem_wr_rd  out  1  1 = write, 0 = read, registered.
- mem_address  out  ADDR_WIDTH  word index = paddr >> ADDR_LSB, zero-extended.
- mem_write_data  out  DATA_WIDTH  registered copy of pwdata.
- mem_read_data  in  DATA_WIDTH  memory read data.
- mem_data_ready  in  1  memory completion.

Behaviour:
- Reset (reset_n=0 at a clk edge), from any state: state=IDLE; prdata, pready, pslverr, mem_en, mem_wr_rd, mem_address, mem_write_data, timeout counter all 0.
- Memory contract:
  - Write completes in the same cycle mem_en=1 with mem_data_ready=1.
  - Read requires mem_en held; mem_data_ready=1 and mem_read_data are valid in the second en cycle.
- FSM states IDLE, MEM, RESP, ERR. Only one transfer is outstanding at a time.
- IDLE:
  - On psel=1 and penable=0 (setup phase), latch pwrite, pwdata and word index.
  - If paddr[ADDR_LSB-1:0] != 0, or word index >= MEM_DEPTH, go to ERR.
  - Otherwise load the mem_* registers, set mem_en=1 and go to MEM.
- MEM:
  - mem_en stays 1.
  - When mem_data_ready=1: for a read, capture mem_read_data into prdata. Then clear mem_en, set pready=1 and pslverr=0, go to RESP.
  - If psel=0 (master aborted): clear mem_en, go to IDLE, no pready. A write already acknowledged by the memory is not undone.
- RESP: pready=1 for exactly one cycle. Then pready goes to 0, go to IDLE. The bridge does not check penable in this state.
- ERR:
  - Entered from IDLE or on timeout. Sets pready=1, pslverr=1 and prdata=0 for one cycle, with mem_en=0. Then go to IDLE.
  - The memory is never accessed for a decode error.
- prdata holds its last value across writes and idle cycles. It is cleared only by reset or ERR.
- Latency, with setup phase in cycle T0:
  - Write: mem_en=1 in T1, pready in T2.
  - Read: mem_en=1 in T1 and T2, pready with prdata in T3.
  - Decode error: pready=pslverr=1 in T1.
- Back-to-back transfers: a new setup phase is sampled in the cycle after RESP/ERR (IDLE). No pipelining.
- Reset mid-transfer: mem_en drops at that edge and no pready is issued.

Optional Feature:
- Macro APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to MEM and increments each MEM cycle with mem_data_ready=0.
  - When the count reaches TIMEOUT_CYCLES, clear mem_en and go to ERR (pslverr response).
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter. MEM waits indefinitely for mem_data_ready.

Test Plan:
- Write pwdata=0xDEADBEEF to paddr=0x10 → T1: mem_en=1, mem_wr_rd=1, mem_address=4, mem_write_data=0xDEADBEEF; T2: pready=1, pslverr=0; T3: pready=0, mem_en=0.
- Read paddr=0x10 after the test above → mem_en=1 in T1 and T2, mem_wr_rd=0; T3: pready=1, prdata=0xDEADBEEF, pslverr=0.
- Read paddr=0x100 (index 64 = MEM_DEPTH) → mem_en never asserted; T1: pready=1, pslverr=1, prdata=0.
- Write to paddr=0x13 (misaligned) → T1: pready=1, pslverr=1, no memory write; a later read of 0x10 still returns 0xDEADBEEF.
- Assert reset_n=0 in T2 of a read → next edge: all outputs 0, state IDLE, no pready. A following write to 0x20 then completes normally with pready in T2.
- With APB_BRIDGE_TIMEOUT_EN and a memory model holding mem_data_ready=0 → pready=1, pslverr=1 after 16 MEM cycles. Without the macro, mem_en stays 1 and pready stays 0 for 100 cycles.

Source files
------------

// File: rtl/apb_mem_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : apb_mem_bridge
// Purpose  : APB slave turning transfers into single-word memory accesses,
//            with decode/alignment errors and an optional access timeout
//            enabled by the macro APB_BRIDGE_TIMEOUT_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
module apb_mem_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  mem_en,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_data_ready
);

  localparam int C_ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] C_DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_MEM  = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;
  localparam logic [1:0] C_ERR  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_misaligned;
  logic                  w_setup;
  logic                  w_decode_err;
  logic                  w_timeout;

  logic [DATA_WIDTH-1:0] w_prdata_nxt;
  logic                  w_pready_nxt;
  logic                  w_pslverr_nxt;
  logic                  w_mem_en_nxt;
  logic                  w_mem_wr_rd_nxt;
  logic [ADDR_WIDTH-1:0] w_mem_address_nxt;
  logic [DATA_WIDTH-1:0] w_mem_write_data_nxt;

  assign w_index = paddr >> C_ADDR_LSB;
  assign w_setup = psel && !penable;

  generate
    if (C_ADDR_LSB > 0) begin : g_align_chk
      assign w_misaligned = |paddr[C_ADDR_LSB-1:0];
    end else begin : g_no_align_chk
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_decode_err = w_misaligned || (w_index >= C_DEPTH);

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;

  // The stall that would bring the count to TIMEOUT_CYCLES ends the access.
  assign w_timeout = !mem_data_ready && (r_cnt == C_CNT_LAST);

  // Held at zero outside MEM, so every MEM visit starts from a clean count.
  always_comb begin
    w_cnt_nxt = '0;
    if (r_state == C_MEM && !mem_data_ready) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= C_IDLE;
      prdata         <= '0;
      pready         <= 1'b0;
      pslverr        <= 1'b0;
      mem_en         <= 1'b0;
      mem_wr_rd      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      r_state        <= w_state_nxt;
      prdata         <= w_prdata_nxt;
      pready         <= w_pready_nxt;
      pslverr        <= w_pslverr_nxt;
      mem_en         <= w_mem_en_nxt;
      mem_wr_rd      <= w_mem_wr_rd_nxt;
      mem_address    <= w_mem_address_nxt;
      mem_write_data <= w_mem_write_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: begin
        if (w_setup) begin
          w_state_nxt = w_decode_err ? C_ERR : C_MEM;
        end
      end
      C_MEM: begin
        if (!psel) begin
          w_state_nxt = C_IDLE;
        end else if (mem_data_ready) begin
          w_state_nxt = C_RESP;
        end else if (w_timeout) begin
          w_state_nxt = C_ERR;
        end
      end
      C_RESP:  w_state_nxt = C_IDLE;
      C_ERR:   w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  // Next values of the registered outputs; pready is a single-cycle pulse.
  always_comb begin
    w_prdata_nxt         = prdata;
    w_pready_nxt         = 1'b0;
    w_pslverr_nxt        = 1'b0;
    w_mem_en_nxt         = mem_en;
    w_mem_wr_rd_nxt      = mem_wr_rd;
    w_mem_address_nxt    = mem_address;
    w_mem_write_data_nxt = mem_write_data;
    case (r_state)
      C_IDLE: begin
        w_mem_en_nxt = 1'b0;
        if (w_setup) begin
          if (w_decode_err) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
            w_prdata_nxt  = '0;
          end else begin
            w_mem_en_nxt         = 1'b1;
            w_mem_wr_rd_nxt      = pwrite;
            w_mem_address_nxt    = w_index;
            w_mem_write_data_nxt = pwdata;
          end
        end
      end
      C_MEM: begin
        if (!psel) begin
          w_mem_en_nxt = 1'b0;
        end else if (mem_data_ready) begin
          w_mem_en_nxt = 1'b0;
          w_pready_nxt = 1'b1;
          if (!mem_wr_rd) begin
            w_prdata_nxt = mem_read_data;
          end
        end else if (w_timeout) begin
          w_mem_en_nxt  = 1'b0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = 1'b1;
          w_prdata_nxt  = '0;
        end
      end
      default: w_mem_en_nxt = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_apb_mem_bridge
// Purpose  : Directed self-checking bench for apb_mem_bridge.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_apb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        mem_en, mem_wr_rd;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_data_ready;

  apb_mem_bridge dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .mem_en         (mem_en),
    .mem_wr_rd      (mem_wr_rd),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_data_ready (mem_data_ready)
  );

  always #5 clk = ~clk;

  // Memory responder: writes ack in the first en cycle, reads in the second.
  logic [31:0] mem_arr [0:63];
  logic        rd_seen = 1'b0;
  logic        mem_stall = 1'b0;

  always_comb begin
    mem_data_ready = 1'b0;
    mem_read_data  = 32'h0;
    if (mem_en && !mem_stall) begin
      if (mem_wr_rd) begin
        mem_data_ready = 1'b1;
      end else if (rd_seen) begin
        mem_data_ready = 1'b1;
        mem_read_data  = mem_arr[mem_address[5:0]];
      end
    end
  end

  int          wr_count = 0;
  int          en_cycles = 0;
  int          rdy_count = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  always @(posedge clk) begin
    rd_seen <= mem_en && !mem_wr_rd;
    if (mem_en) en_cycles <= en_cycles + 1;
    if (pready) rdy_count <= rdy_count + 1;
    if (mem_en && mem_wr_rd && mem_data_ready) begin
      mem_arr[mem_address[5:0]] <= mem_write_data;
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_address;
      last_wr_data <= mem_write_data;
    end
  end

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle expectation produced from the transfer-level latency rules.
  typedef struct packed {
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        err;
    logic        setp;
    logic [31:0] prv;
    logic        zero;
  } exp_t;

  localparam exp_t E_IDLE = '0;

  exp_t        expq[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] exp_prdata = 32'h0;
  logic        cmp_on = 1'b0;

  function automatic exp_t mk(input logic en, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rdy, input logic err,
                              input logic setp, input logic [31:0] prv, input logic zero);
    exp_t e;
    e.en = en; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdy = rdy;
    e.err = err; e.setp = setp; e.prv = prv; e.zero = zero;
    return e;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      exp_t        e;
      logic [31:0] want_pr;
      e = (expq.size() > 0) ? expq.pop_front() : E_IDLE;
      want_pr = e.setp ? e.prv : exp_prdata;
      exp_prdata <= want_pr;
      chk("mem_en", 32'(mem_en), 32'(e.en));
      chk("pready", 32'(pready), 32'(e.rdy));
      chk("prdata", prdata, want_pr);
      if (e.rdy) chk("pslverr", 32'(pslverr), 32'(e.err));
      if (e.en) begin
        chk("mem_wr_rd", 32'(mem_wr_rd), 32'(e.wr));
        chk("mem_address", mem_address, e.addr);
        if (e.wr) chk("mem_write_data", mem_write_data, e.wdata);
      end
      if (e.zero) begin
        chk("zero_pslverr", 32'(pslverr), 32'h0);
        chk("zero_wr_rd", 32'(mem_wr_rd), 32'h0);
        chk("zero_address", mem_address, 32'h0);
        chk("zero_wdata", mem_write_data, 32'h0);
      end
    end
  end

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] idx;
    logic        bad;
    idx = addr >> 2;
    bad = (addr[1:0] != 2'b00) || (idx >= 32'd64);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    step(E_IDLE);
    penable = 1'b1;
    if (bad) begin
      step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0));
    end else begin
      step(mk(1'b1, wr, idx, data, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
      if (!wr) step(mk(1'b1, 1'b0, idx, data, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
      if (wr) model_mem[idx] = data;
      step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, !wr, wr ? 32'h0 : model_mem[idx], 1'b0));
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    @(posedge clk); #1;
    cmp_on = 1'b1;
    chk("reset_prdata", prdata, 32'h0);
    chk("reset_pready", 32'(pready), 32'h0);
    chk("reset_mem_en", 32'(mem_en), 32'h0);
    step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1));
    step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1));
    reset_n = 1'b1;
    step(E_IDLE);
    step(E_IDLE);

    apb_xfer(1'b1, 32'h10, 32'hDEADBEEF);
    chk("wr_addr_literal", last_wr_addr, 32'h4);
    chk("wr_data_literal", last_wr_data, 32'hDEADBEEF);
    chk("wr_count_literal", 32'(wr_count), 32'h1);
    step(E_IDLE);
    apb_xfer(1'b0, 32'h10, 32'h0);
    chk("rd_literal", prdata, 32'hDEADBEEF);

    saved = en_cycles;
    apb_xfer(1'b0, 32'h100, 32'h0);
    chk("range_err_prdata", prdata, 32'h0);
    chk("range_err_no_mem", 32'(en_cycles), 32'(saved));
    apb_xfer(1'b1, 32'h13, 32'h11111111);
    chk("misaligned_no_write", 32'(wr_count), 32'h1);
    apb_xfer(1'b0, 32'h10, 32'h0);
    chk("reread_literal", prdata, 32'hDEADBEEF);

    apb_xfer(1'b1, 32'h4, 32'h12345678);
    apb_xfer(1'b1, 32'hFC, 32'hA5A55A5A);
    apb_xfer(1'b0, 32'hFC, 32'h0);
    chk("last_word_literal", prdata, 32'hA5A55A5A);
    apb_xfer(1'b0, 32'h4, 32'h0);
    apb_xfer(1'b1, 32'h200, 32'h22222222);
    apb_xfer(1'b1, 32'h8, 32'h0BADF00D);
    chk("prdata_hold_literal", prdata, 32'h0);
    step(E_IDLE);

    // Reset during the second memory cycle of a read.
    saved = rdy_count;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4; pwdata = 32'h0;
    step(E_IDLE);
    penable = 1'b1;
    step(mk(1'b1, 1'b0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    reset_n = 1'b0;
    step(mk(1'b1, 1'b0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    reset_n = 1'b1; psel = 1'b0; penable = 1'b0;
    step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1));
    step(E_IDLE);
    chk("reset_no_pready", 32'(rdy_count), 32'(saved));
    apb_xfer(1'b1, 32'h20, 32'hCAFEF00D);
    chk("post_reset_wr_addr", last_wr_addr, 32'h8);
    apb_xfer(1'b0, 32'h20, 32'h0);
    chk("post_reset_rd", prdata, 32'hCAFEF00D);

    // Memory that never answers.
    saved = rdy_count;
    mem_stall = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10; pwdata = 32'h0;
    step(E_IDLE);
    penable = 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 16; i++) step(mk(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    step(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0));
    chk("timeout_one_pready", 32'(rdy_count), 32'(saved + 1));
`else
    for (int i = 0; i < 100; i++) step(mk(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    psel = 1'b0; penable = 1'b0;
    step(mk(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    chk("stall_no_pready", 32'(rdy_count), 32'(saved));
    chk("abort_mem_en", 32'(mem_en), 32'h0);
`endif
    psel = 1'b0; penable = 1'b0; mem_stall = 1'b0;
    step(E_IDLE);
    apb_xfer(1'b0, 32'h10, 32'h0);
    chk("after_stall_rd", prdata, 32'hDEADBEEF);
    step(E_IDLE);
    step(E_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
